reptile_core: RTL and testbench
===============================

# reptile_core

Parametrised multi-cycle Reptile CPU core: fetches 16-bit-format instructions over a stallable req/ack memory port, executes them through a single FSM, and owns the 8-entry register bank, zero flag and program counter. It is the next generation of the Reptile-8 CPU. Relative to Reptile-8 it adds:
- data and address widths set by parameter;
- a wait-state memory handshake;
- an immediate-load instruction and a HALT state.

## Interface
- DW, 16, data/register width; must be ≥ 16.
- AW, 12, address/PC width; must be ≥ 12.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_rdata  in  DW  read data; valid when mem_ack=1.
- mem_ack  in  1  completes the current request this cycle.
- mem_req  out  1  memory request; held high until acked.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  AW  request address.
- mem_wdata  out  DW  store data; valid while mem_req & mem_we.
- halted  out  1  high in HALTED state.
- zf  out  1  zero flag.

## Operation
- **Instruction fields:**
  - Bits above 15 are ignored. instr[15] is reserved and ignored.
  - op = instr[14:12], dest = [11:9], s1 = [8:6], s2 = [5:3], fn = [2:0], off = [11:0].
- **op 0, ALU:**
  - R[dest] <= f(R[s1], R[s2]), modulo 2^DW.
  - fn: 0 ADD, 1 SUB (s1−s2), 2 AND, 3 OR, 4 XOR, 5 NOT s1, 6 SHL1 s1, 7 SHR1 s1 (logical).
  - zf <= (result == 0).
- **op 1, LD:** R[dest] <= mem[R[s2][AW-1:0]].
- **op 2, ST:** mem[R[s2][AW-1:0]] <= R[s1].
- **op 3, JMP:** PC <= IA + sext(off), truncated to AW, where IA is the address of this instruction.
- **op 4, JZ:** same target as JMP if zf=1, otherwise fall through.
- **op 5, LDI:** R[dest] <= zero-extended instr[8:0].
- **op 6, HALT:** enter HALTED.
- **op 7:** NOP.
- **Flag scope:** only ALU ops write zf. LD and LDI do not.
- **FSM states:** BOOT, FETCH, EXEC, MEM, HALTED.
  - BOOT: one cycle after reset release, then FETCH.
  - FETCH:
    - mem_req=1, mem_we=0, mem_addr=PC.
    - On ack: IR <= mem_rdata, IA <= PC, PC <= PC+1 (wraps 2^AW−1 → 0), go to EXEC.
  - EXEC:
    - ALU, LDI, JMP, JZ and NOP complete here and go to FETCH.
    - LD and ST go to MEM.
    - HALT goes to HALTED.
  - MEM:
    - mem_req=1, mem_addr=R[s2][AW-1:0]. mem_we=1 and mem_wdata=R[s1] for ST.
    - On ack, LD writes R[dest] <= mem_rdata. Go to FETCH.
  - HALTED: mem_req=0. Left only by rst.
- **Request outputs:** mem_req, mem_we and mem_addr decode from the state and the registered IR/PC, with no combinational path from mem_ack.
  - The address and data are stable for the whole request.
  - mem_ack while mem_req=0 is ignored.
- **Register reads:** asynchronous. Source registers equal to dest read the old value.

## Timing
- **Reset (async):**
  - state=BOOT, PC=0, R0..R7=0, zf=0, IR=0.
  - mem_req=0, mem_we=0, halted=0 immediately on rst assertion.
- **Mid-transaction reset:** an in-flight request is abandoned, mem_req drops without waiting for ack, and no register write occurs.
- **First fetch:** mem_req first rises in the second cycle after rst deasserts.
- **Cycles per instruction with zero-wait ack:**
  - ALU, LDI, JMP, JZ, NOP: 2 cycles.
  - LD, ST: 3 cycles.
  - Each cycle without ack adds one cycle.
- **Write visibility:** register and zf writes happen at the EXEC or MEM clock edge and are visible to the next instruction.
- **Self-jump:** JMP with off=0 loops forever, 2 cycles per iteration.

## Test plan
- **Reset and boot:** assert rst mid-fetch with an ack-stalling memory.
  - mem_req drops at once.
  - After release: one BOOT cycle, then a fetch from address 0.
  - All registers read 0.
- **LDI/ALU program:** LDI R1,5; LDI R2,5; SUB R3,R1,R2; ADD R4,R1,R2.
  - Result: R3=0, R4=10.
  - zf=1 after the SUB and 0 after the ADD.
  - Each instruction takes 2 cycles with zero-wait ack.
- **Memory stall:** ack delayed 3 cycles on every request.
  - mem_addr and mem_wdata stay constant while req is high.
  - ST R1→[R2] writes the correct value.
  - LD reads it back into R5.
  - CPI is 5 for ALU and 9 for LD/ST.
- **Branches:** JZ at address 0x010 with off=0xFF0 (−16).
  - With zf=1 the next fetch is at 0x000.
  - With zf=0 the next fetch is at 0x011.
  - JMP with off=0 refetches the same address.
- **Wrap and width:**
  - With DW=32, AW=16: ADD 0xFFFFFFFF+1 gives 0 with zf=1. SHR1 of 0x80000000 gives 0x40000000.
  - A fetch at PC=0xFFFF is followed by a fetch at 0x0000.
- **HALT:**
  - After HALT, halted=1 and mem_req stays 0 for 100 cycles. Spurious mem_ack is ignored.
  - rst restarts fetch at 0.

Source files
------------

// File: rtl/reptile_core.sv
// Reptile multi-cycle CPU core: one FSM fetches 16-bit-format instructions over a
// stallable req/ack port and executes them against an 8-entry register bank.
module reptile_core #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_halted,
  output logic          o_zf
);

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StExec,
    StMem,
    StHalted
  } state_e;

  state_e        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_ia;
  logic [14:0]   r_ir;
  logic [DW-1:0] r_regs [8];
  logic          r_zf;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_halted;

  logic [2:0]    w_op;
  logic [2:0]    w_dest;
  logic [2:0]    w_s1;
  logic [2:0]    w_s2;
  logic [2:0]    w_fn;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_alu;
  logic [AW-1:0] w_off_ext;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_pc_exec;

  assign w_op   = r_ir[14:12];
  assign w_dest = r_ir[11:9];
  assign w_s1   = r_ir[8:6];
  assign w_s2   = r_ir[5:3];
  assign w_fn   = r_ir[2:0];
  assign w_a    = r_regs[w_s1];
  assign w_b    = r_regs[w_s2];

  always_comb begin
    w_alu = '0;
    case (w_fn)
      3'd0: w_alu = w_a + w_b;
      3'd1: w_alu = w_a - w_b;
      3'd2: w_alu = w_a & w_b;
      3'd3: w_alu = w_a | w_b;
      3'd4: w_alu = w_a ^ w_b;
      3'd5: w_alu = ~w_a;
      3'd6: w_alu = {w_a[DW-2:0], 1'b0};
      3'd7: w_alu = {1'b0, w_a[DW-1:1]};
      default: w_alu = '0;
    endcase
  end

  // Branch offsets are relative to the branch's own address, not the incremented PC.
  always_comb begin
    w_off_ext       = {AW{r_ir[11]}};
    w_off_ext[11:0] = r_ir[11:0];
  end

  assign w_target  = r_ia + w_off_ext;
  assign w_pc_exec = ((w_op == 3'd3) || ((w_op == 3'd4) && r_zf)) ? w_target : r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StBoot;
      r_pc     <= '0;
      r_ia     <= '0;
      r_ir     <= '0;
      r_zf     <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_halted <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        StBoot: begin
          r_state <= StFetch;
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= r_pc;
        end
        StFetch: begin
          if (i_mem_ack) begin
            r_ir    <= i_mem_rdata[14:0];
            r_ia    <= r_pc;
            r_pc    <= r_pc + AW'(1);
            r_req   <= 1'b0;
            r_state <= StExec;
          end
        end
        StExec: begin
          // Default: next fetch is issued directly from here, at the resolved PC.
          r_state <= StFetch;
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= w_pc_exec;
          r_pc    <= w_pc_exec;
          case (w_op)
            3'd0: begin
              r_regs[w_dest] <= w_alu;
              r_zf           <= (w_alu == '0);
            end
            3'd1: begin
              r_state <= StMem;
              r_addr  <= w_b[AW-1:0];
            end
            3'd2: begin
              r_state <= StMem;
              r_addr  <= w_b[AW-1:0];
              r_we    <= 1'b1;
              r_wdata <= w_a;
            end
            3'd5: r_regs[w_dest] <= DW'(r_ir[8:0]);
            3'd6: begin
              r_state  <= StHalted;
              r_req    <= 1'b0;
              r_halted <= 1'b1;
            end
            default: ;
          endcase
        end
        StMem: begin
          if (i_mem_ack) begin
            if (!r_we) r_regs[w_dest] <= i_mem_rdata;
            r_state <= StFetch;
            r_we    <= 1'b0;
            r_addr  <= r_pc;
          end
        end
        StHalted: ;
        default: r_state <= StHalted;
      endcase
    end
  end

  assign o_mem_req   = r_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_halted    = r_halted;
  assign o_zf        = r_zf;

endmodule

// File: tb/tb_reptile_core.sv
// Directed bench for reptile_core (DW=32, AW=16) with a wait-state memory model,
// a table of ALU vectors and hand-built programs for reset, stall, branch and halt cases.
module tb_reptile_core;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          halted;
  logic          zf;

  reptile_core #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_mem_rdata (rdata),
    .i_mem_ack   (ack),
    .o_mem_req   (req),
    .o_mem_we    (we),
    .o_mem_addr  (addr),
    .o_mem_wdata (wdata),
    .o_halted    (halted),
    .o_zf        (zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:65535];
  int            checks = 0;
  int            fails  = 0;
  int            cyc    = 0;
  int            cnt    = 0;
  int            waitc  = 0;
  int            unstable = 0;
  logic          spur   = 1'b0;
  logic [AW-1:0] h_addr;
  logic          h_we;
  logic [DW-1:0] h_wdata;
  logic [AW-1:0] rl_addr [$];
  int            rl_cyc  [$];
  logic          rl_zf   [$];
  logic [AW-1:0] wl_addr [$];
  logic [DW-1:0] wl_data [$];

  typedef struct {
    logic [2:0]    fn;
    logic [8:0]    a;
    logic [8:0]    b;
    logic [DW-1:0] res;
    logic          zf;
  } alu_vec_t;
  alu_vec_t vecs [10];

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [11:0] f);
    return {1'b0, op, f};
  endfunction
  function automatic logic [15:0] alu(input logic [2:0] fn, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b);
    return enc(3'd0, {d, a, b, fn});
  endfunction
  function automatic logic [15:0] ld(input logic [2:0] d, input logic [2:0] s2);
    return enc(3'd1, {d, 3'd0, s2, 3'd0});
  endfunction
  function automatic logic [15:0] st(input logic [2:0] s1, input logic [2:0] s2);
    return enc(3'd2, {3'd0, s1, s2, 3'd0});
  endfunction
  function automatic logic [15:0] jmp(input logic [11:0] off);
    return enc(3'd3, off);
  endfunction
  function automatic logic [15:0] jz(input logic [11:0] off);
    return enc(3'd4, off);
  endfunction
  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [8:0] imm);
    return enc(3'd5, {d, imm});
  endfunction
  function automatic logic [15:0] op_halt();
    return enc(3'd6, 12'd0);
  endfunction

  function automatic int rcyc(input int i);
    return (i < rl_cyc.size()) ? rl_cyc[i] : -100000;
  endfunction
  function automatic logic [AW-1:0] raddr(input int i);
    return (i < rl_addr.size()) ? rl_addr[i] : 'x;
  endfunction
  function automatic logic rzf(input int i);
    return (i < rl_zf.size()) ? rl_zf[i] : 1'bx;
  endfunction
  function automatic logic [AW-1:0] waddr(input int i);
    return (i < wl_addr.size()) ? wl_addr[i] : 'x;
  endfunction
  function automatic logic [DW-1:0] wdat(input int i);
    return (i < wl_data.size()) ? wl_data[i] : 'x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of the memory model, evaluated at the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst) begin
      ack = 1'b0;
      cnt = 0;
    end else if (req) begin
      if (cnt == 0) begin
        h_addr  = addr;
        h_we    = we;
        h_wdata = wdata;
      end else if (addr !== h_addr || we !== h_we || (we && wdata !== h_wdata)) begin
        unstable++;
      end
      if (cnt >= waitc) begin
        ack   = 1'b1;
        rdata = mem[addr];
        if (we) begin
          mem[addr] = wdata;
          wl_addr.push_back(addr);
          wl_data.push_back(wdata);
        end else begin
          rl_addr.push_back(addr);
          rl_cyc.push_back(cyc);
          rl_zf.push_back(zf);
        end
        cnt = 0;
      end else begin
        ack = 1'b0;
        cnt++;
      end
    end else begin
      ack = spur;
      cnt = 0;
    end
  endtask

  task automatic begin_test();
    rst  = 1'b1;
    ack  = 1'b0;
    spur = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
  endtask

  task automatic release_rst(input int w);
    rl_addr.delete();
    rl_cyc.delete();
    rl_zf.delete();
    wl_addr.delete();
    wl_data.delete();
    cnt      = 0;
    unstable = 0;
    waitc    = w;
    spur     = 1'b0;
    ack      = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_halted"}, halted, 1'b1);
  endtask

  task automatic put(input int a, input logic [15:0] ins);
    mem[a] = {16'h0000, ins};
  endtask

  initial begin
    logic [AW-1:0] br_exp [9];
    int bad;
    rst   = 1'b1;
    ack   = 1'b0;
    rdata = '0;

    vecs[0] = '{3'd0, 9'h005, 9'h005, 32'h0000000A, 1'b0};
    vecs[1] = '{3'd1, 9'h005, 9'h005, 32'h00000000, 1'b1};
    vecs[2] = '{3'd1, 9'h003, 9'h005, 32'hFFFFFFFE, 1'b0};
    vecs[3] = '{3'd2, 9'h1F0, 9'h0FF, 32'h000000F0, 1'b0};
    vecs[4] = '{3'd3, 9'h100, 9'h0FF, 32'h000001FF, 1'b0};
    vecs[5] = '{3'd4, 9'h155, 9'h155, 32'h00000000, 1'b1};
    vecs[6] = '{3'd5, 9'h000, 9'h1FF, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{3'd6, 9'h1FF, 9'h000, 32'h000003FE, 1'b0};
    vecs[8] = '{3'd7, 9'h001, 9'h000, 32'h00000000, 1'b1};
    vecs[9] = '{3'd7, 9'h1FE, 9'h1FF, 32'h000000FF, 1'b0};

    // Reset mid-fetch against a stalling memory, then dump R0..R7.
    begin_test();
    for (int k = 0; k < 8; k++) put(k, st(3'(k), 3'd0));
    put(8, op_halt());
    release_rst(1000);
    tick();
    tick();
    chk("stall_req_up", req, 1'b1);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("rst_req_drop", req, 1'b0);
    chk("rst_we_low", we, 1'b0);
    chk("rst_halted_low", halted, 1'b0);
    release_rst(0);
    tick();
    chk("boot_req_low", req, 1'b0);
    tick();
    chk("first_req", req, 1'b1);
    chk("first_addr", addr, 16'h0000);
    run_halt("dump", 200);
    chk("dump_nwrites", wl_data.size(), 8);
    for (int k = 0; k < 8; k++) chk($sformatf("dump_r%0d", k), wdat(k), 32'h0);
    chk("dump_zf", zf, 1'b0);

    // ALU table.
    for (int v = 0; v < 10; v++) begin
      begin_test();
      put(0, ldi(3'd1, vecs[v].a));
      put(1, ldi(3'd2, vecs[v].b));
      put(2, alu(vecs[v].fn, 3'd3, 3'd1, 3'd2));
      put(3, ldi(3'd4, 9'h1F0));
      put(4, st(3'd3, 3'd4));
      put(5, op_halt());
      release_rst(0);
      run_halt($sformatf("alu%0d", v), 200);
      chk($sformatf("alu%0d_res", v), wdat(0), vecs[v].res);
      chk($sformatf("alu%0d_zf", v), zf, vecs[v].zf);
      if (v == 0) chk("alu_st_addr", waddr(0), 16'h01F0);
    end

    // LDI/ALU program with junk in bits 31:15, CPI and zf timing, then HALT idle.
    begin_test();
    put(0, ldi(3'd1, 9'd5));
    put(1, ldi(3'd2, 9'd5));
    put(2, alu(3'd1, 3'd3, 3'd1, 3'd2));
    put(3, alu(3'd0, 3'd4, 3'd1, 3'd2));
    put(4, ldi(3'd5, 9'h1F0));
    put(5, st(3'd3, 3'd5));
    put(6, ldi(3'd6, 9'h1F1));
    put(7, st(3'd4, 3'd6));
    put(8, alu(3'd0, 3'd1, 3'd1, 3'd2));
    put(9, st(3'd1, 3'd5));
    put(10, op_halt());
    for (int i = 0; i <= 10; i++) mem[i] = mem[i] | 32'hA5A58000;
    release_rst(0);
    run_halt("prog", 200);
    for (int k = 0; k < 4; k++) chk($sformatf("prog_cpi%0d", k), rcyc(k + 1) - rcyc(k), 2);
    chk("prog_zf_after_sub", rzf(3), 1'b1);
    chk("prog_zf_after_add", rzf(4), 1'b0);
    chk("prog_nwrites", wl_data.size(), 3);
    chk("prog_w0_addr", waddr(0), 16'h01F0);
    chk("prog_w0", wdat(0), 32'd0);
    chk("prog_w1_addr", waddr(1), 16'h01F1);
    chk("prog_w1", wdat(1), 32'd10);
    chk("prog_w2_srcdest", wdat(2), 32'd10);
    spur = 1'b1;
    bad  = 0;
    repeat (100) begin
      tick();
      if (req !== 1'b0 || halted !== 1'b1) bad++;
    end
    chk("halt_idle_bad", bad, 0);
    chk("halt_no_writes", wl_data.size(), 3);
    chk("halt_no_reads", rl_addr.size(), 11);
    rst = 1'b1;
    release_rst(0);
    tick();
    tick();
    chk("restart_addr", raddr(0), 16'h0000);
    chk("restart_halted", halted, 1'b0);

    // Three wait states on every request.
    begin_test();
    put(0, ldi(3'd1, 9'h123));
    put(1, alu(3'd1, 3'd7, 3'd0, 3'd0));
    put(2, ldi(3'd2, 9'h1F0));
    put(3, st(3'd1, 3'd2));
    put(4, ld(3'd5, 3'd2));
    put(5, ldi(3'd6, 9'h1F1));
    put(6, st(3'd5, 3'd6));
    put(7, op_halt());
    release_rst(3);
    run_halt("stall", 400);
    chk("stall_cpi_alu", rcyc(2) - rcyc(1), 5);
    chk("stall_cpi_st", rcyc(4) - rcyc(3), 9);
    chk("stall_cpi_ld", rcyc(6) - rcyc(4), 9);
    chk("stall_ld_addr", raddr(5), 16'h01F0);
    chk("stall_last_fetch", raddr(8), 16'h0007);
    chk("stall_nwrites", wl_data.size(), 2);
    chk("stall_st_addr", waddr(0), 16'h01F0);
    chk("stall_st_data", wdat(0), 32'h123);
    chk("stall_ld_data", wdat(1), 32'h123);
    chk("stall_unstable", unstable, 0);
    chk("stall_zf_kept", zf, 1'b1);

    // JZ not taken then taken, both landing as relative targets.
    begin_test();
    put(0, ldi(3'd1, 9'd1));
    put(1, alu(3'd0, 3'd2, 3'd1, 3'd0));
    put(2, jmp(12'd14));
    put(16, jz(12'hFF0));
    put(17, alu(3'd1, 3'd3, 3'd1, 3'd1));
    put(18, jmp(12'hFFE));
    release_rst(0);
    repeat (40) tick();
    br_exp = '{16'h00, 16'h01, 16'h02, 16'h10, 16'h11, 16'h12, 16'h10, 16'h00, 16'h01};
    for (int k = 0; k < 9; k++) chk($sformatf("branch_fetch%0d", k), raddr(k), br_exp[k]);

    // Self-jump.
    begin_test();
    put(0, jmp(12'd0));
    release_rst(0);
    repeat (20) tick();
    for (int k = 0; k < 4; k++) chk($sformatf("selfjmp_addr%0d", k), raddr(k), 16'h0000);
    chk("selfjmp_cpi", rcyc(3) - rcyc(2), 2);

    // PC wrap at 2^AW-1.
    begin_test();
    put(0, jmp(12'hFFF));
    put(65535, ldi(3'd1, 9'h055));
    release_rst(0);
    repeat (20) tick();
    chk("wrap_f1", raddr(1), 16'hFFFF);
    chk("wrap_f2", raddr(2), 16'h0000);
    chk("wrap_f3", raddr(3), 16'hFFFF);

    // Full-width arithmetic.
    begin_test();
    put(0, ldi(3'd1, 9'd0));
    put(1, alu(3'd5, 3'd1, 3'd1, 3'd0));
    put(2, ldi(3'd2, 9'd1));
    put(3, alu(3'd0, 3'd3, 3'd1, 3'd2));
    put(4, ldi(3'd4, 9'h100));
    put(5, ld(3'd5, 3'd4));
    put(6, alu(3'd7, 3'd6, 3'd5, 3'd0));
    put(7, ldi(3'd7, 9'h1F0));
    put(8, st(3'd3, 3'd7));
    put(9, st(3'd6, 3'd7));
    put(10, st(3'd1, 3'd7));
    put(11, alu(3'd0, 3'd1, 3'd1, 3'd2));
    put(12, st(3'd1, 3'd7));
    put(13, op_halt());
    mem[256] = 32'h80000000;
    release_rst(0);
    run_halt("wide", 300);
    chk("wide_zf_not", rzf(2), 1'b0);
    chk("wide_zf_add", rzf(4), 1'b1);
    chk("wide_add_wrap", wdat(0), 32'h00000000);
    chk("wide_shr1", wdat(1), 32'h40000000);
    chk("wide_not", wdat(2), 32'hFFFFFFFF);
    chk("wide_srcdest", wdat(3), 32'h00000000);
    chk("wide_zf_end", zf, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
